// File: rtl/wb_master_cmd.sv
// Single-outstanding Wishbone classic master: one valid/ready command becomes one
// bus cycle, and its outcome (ok, bus error or timeout) is returned on a valid/ready response.
module wb_master_cmd #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int BYTE_EN_WIDTH  = BUS_DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [BUS_ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [BYTE_EN_WIDTH-1:0]  cmd_sel_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [BUS_DATA_WIDTH-1:0] rsp_dat_o,
  output logic [1:0]                rsp_status_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [BYTE_EN_WIDTH-1:0]  wbm_sel_o,
  output logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [BUS_DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                      wbm_ack_i,
  input  logic                      wbm_err_i
);

  // Counter holds 0..TIMEOUT_CYCLES-1; at least one bit so the disabled case still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUS_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      cmd_ready_nxt, rsp_valid_nxt;
  logic [BUS_DATA_WIDTH-1:0] rsp_dat_nxt;
  logic [1:0]                rsp_status_nxt;
  logic                      cyc_nxt, we_nxt;
  logic [BYTE_EN_WIDTH-1:0]  sel_nxt;
  logic [BUS_ADDR_WIDTH-1:0] adr_nxt;
  logic [BUS_DATA_WIDTH-1:0] dat_nxt;
  logic                      result;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cmd_ready_nxt  = cmd_ready_o;
    rsp_valid_nxt  = rsp_valid_o;
    rsp_dat_nxt    = rsp_dat_o;
    rsp_status_nxt = rsp_status_o;
    cyc_nxt        = wbm_cyc_o;
    we_nxt         = wbm_we_o;
    sel_nxt        = wbm_sel_o;
    adr_nxt        = wbm_adr_o;
    dat_nxt        = wbm_dat_o;
    result         = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          we_nxt        = cmd_we_i;
          adr_nxt       = cmd_adr_i;
          dat_nxt       = cmd_dat_i;
          sel_nxt       = cmd_sel_i;
          cyc_nxt       = 1'b1;
          cnt_nxt       = '0;
          cmd_ready_nxt = 1'b0;
          state_nxt     = BUS;
        end
      end
      BUS: begin
        // Error outranks ack, and ack outranks a timeout landing on the same edge.
        if (wbm_err_i) begin
          result         = 1'b1;
          rsp_status_nxt = ST_BUS_ERR;
          rsp_dat_nxt    = '0;
        end else if (wbm_ack_i) begin
          result         = 1'b1;
          rsp_status_nxt = ST_OK;
          rsp_dat_nxt    = wbm_we_o ? '0 : wbm_dat_i;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
          result         = 1'b1;
          rsp_status_nxt = ST_TIMEOUT;
          rsp_dat_nxt    = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (result) begin
          cyc_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= ST_OK;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_sel_o    <= '0;
      wbm_adr_o    <= '0;
      wbm_dat_o    <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cmd_ready_o  <= cmd_ready_nxt;
      rsp_valid_o  <= rsp_valid_nxt;
      rsp_dat_o    <= rsp_dat_nxt;
      rsp_status_o <= rsp_status_nxt;
      wbm_cyc_o    <= cyc_nxt;
      wbm_stb_o    <= cyc_nxt;
      wbm_we_o     <= we_nxt;
      wbm_sel_o    <= sel_nxt;
      wbm_adr_o    <= adr_nxt;
      wbm_dat_o    <= dat_nxt;
    end
  end

endmodule

// File: tb/tb_wb_master_cmd.sv
// Directed bench for wb_master_cmd: each task drives one scenario and checks the
// registered outputs on the falling edge against hand-computed values.
module tb_wb_master_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [7:0]  adr;
  logic [31:0] dat_o, dat_i;
  logic        ack, err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wb_master_cmd #(
    .BUS_DATA_WIDTH(32), .BUS_ADDR_WIDTH(8), .BYTE_EN_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
    .wbm_ack_i(ack), .wbm_err_i(err)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put_cmd(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vecs++;
    if ({cmd_ready, rsp_valid, cyc, stb, we} !== 5'b10000) begin
      errs++; $display("FAIL reset_ctrl: got %b want 10000", {cmd_ready, rsp_valid, cyc, stb, we});
    end
    vecs++;
    if ({rsp_dat, rsp_status, sel, adr, dat_o} !== 78'd0) begin
      errs++; $display("FAIL reset_data: got %h want 0", {rsp_dat, rsp_status, sel, adr, dat_o});
    end
    rst = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vecs++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errs++; $display("FAIL idle_stray_ack: rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_zero_wait();
    rsp_ready = 1'b1;
    put_cmd(1'b0, 8'h00, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    vecs++;
    if ({cyc, stb, we, cmd_ready} !== 4'b1100 || adr !== 8'h00) begin
      errs++; $display("FAIL rd_bus: cyc/stb/we/rdy=%b adr=%h want 1100 00", {cyc, stb, we, cmd_ready}, adr);
    end
    dat_i = 32'hEEEEEEEE; ack = 1'b1;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    vecs++;
    if (cyc !== 1'b0 || rsp_valid !== 1'b1 || rsp_dat !== 32'hEEEEEEEE || rsp_status !== 2'b00 || cmd_ready !== 1'b0) begin
      errs++; $display("FAIL rd_rsp: cyc=%b vld=%b dat=%h st=%b rdy=%b want 0 1 eeeeeeee 00 0",
                       cyc, rsp_valid, rsp_dat, rsp_status, cmd_ready);
    end
    tick();
    vecs++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_dat !== 32'hEEEEEEEE) begin
      errs++; $display("FAIL rd_done: vld=%b rdy=%b dat=%h want 0 1 eeeeeeee", rsp_valid, cmd_ready, rsp_dat);
    end
  endtask

  task automatic test_ack_err();
    put_cmd(1'b0, 8'h08, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    dat_i = 32'h55555555; ack = 1'b1; err = 1'b1;
    tick();
    ack = 1'b0; err = 1'b0; dat_i = 32'h0;
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_dat !== 32'h0) begin
      errs++; $display("FAIL ack_err: vld=%b st=%b dat=%h want 1 01 00000000", rsp_valid, rsp_status, rsp_dat);
    end
    tick();
  endtask

  task automatic test_write_wait();
    put_cmd(1'b1, 8'h04, 32'h12345678, 4'hF);
    tick();
    cmd_valid = 1'b0; cmd_dat = 32'h0; cmd_adr = 8'hFF; cmd_sel = 4'h0;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if ({cyc, stb, we} !== 3'b111 || adr !== 8'h04 || dat_o !== 32'h12345678 || sel !== 4'hF) begin
        errs++; $display("FAIL wr_hold%0d: cyc/stb/we=%b adr=%h dat=%h sel=%h want 111 04 12345678 f",
                         i, {cyc, stb, we}, adr, dat_o, sel);
      end
      if (i == 3) ack = 1'b1;
      tick();
    end
    ack = 1'b0;
    vecs++;
    if (cyc !== 1'b0 || rsp_valid !== 1'b1 || rsp_dat !== 32'h0 || rsp_status !== 2'b00) begin
      errs++; $display("FAIL wr_rsp: cyc=%b vld=%b dat=%h st=%b want 0 1 00000000 00", cyc, rsp_valid, rsp_dat, rsp_status);
    end
    tick();
  endtask

  task automatic test_ack_at_timeout();
    put_cmd(1'b0, 8'h10, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    vecs++;
    if (cyc !== 1'b1) begin
      errs++; $display("FAIL ack16_cyc: cyc=%b want 1 in cycle 16", cyc);
    end
    dat_i = 32'hCAFEF00D; ack = 1'b1;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_dat !== 32'hCAFEF00D) begin
      errs++; $display("FAIL ack16_rsp: vld=%b st=%b dat=%h want 1 00 cafef00d", rsp_valid, rsp_status, rsp_dat);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    put_cmd(1'b0, 8'h80, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    vecs++;
    if (cmd_ready !== 1'b0) begin
      errs++; $display("FAIL to_ready: cmd_ready=%b want 0 in BUS", cmd_ready);
    end
    n = 0;
    while (cyc === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    vecs++;
    if (n !== 16) begin
      errs++; $display("FAIL to_len: cyc high %0d cycles want 16", n);
    end
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_dat !== 32'h0) begin
      errs++; $display("FAIL to_rsp: vld=%b st=%b dat=%h want 1 10 00000000", rsp_valid, rsp_status, rsp_dat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    put_cmd(1'b0, 8'h20, 32'h0, 4'hF);
    tick();
    put_cmd(1'b1, 8'h30, 32'hDEADBEEF, 4'h3);
    dat_i = 32'h13579BDF; ack = 1'b1;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h13579BDF || rsp_status !== 2'b00 || cmd_ready !== 1'b0 || cyc !== 1'b0) begin
        errs++; $display("FAIL bp_hold%0d: vld=%b dat=%h st=%b rdy=%b cyc=%b want 1 13579bdf 00 0 0",
                         i, rsp_valid, rsp_dat, rsp_status, cmd_ready, cyc);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    vecs++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc !== 1'b0) begin
      errs++; $display("FAIL bp_release: vld=%b rdy=%b cyc=%b want 0 1 0", rsp_valid, cmd_ready, cyc);
    end
    tick();
    cmd_valid = 1'b0;
    vecs++;
    if ({cyc, we} !== 2'b11 || adr !== 8'h30 || dat_o !== 32'hDEADBEEF || sel !== 4'h3 || cmd_ready !== 1'b0) begin
      errs++; $display("FAIL bp_second: cyc/we=%b adr=%h dat=%h sel=%h rdy=%b want 11 30 deadbeef 3 0",
                       {cyc, we}, adr, dat_o, sel, cmd_ready);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int stray;
    rsp_ready = 1'b1;
    put_cmd(1'b0, 8'h40, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if ({cyc, stb, cmd_ready, rsp_valid} !== 4'b0010 || adr !== 8'h00) begin
      errs++; $display("FAIL rst_mid: cyc/stb/rdy/vld=%b adr=%h want 0010 00", {cyc, stb, cmd_ready, rsp_valid}, adr);
    end
    dat_i = 32'h77777777; ack = 1'b1;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 1'b0 || cyc !== 1'b0) stray++;
      tick();
    end
    vecs++;
    if (stray !== 0 || rsp_dat !== 32'h0 || cmd_ready !== 1'b1) begin
      errs++; $display("FAIL rst_stray: bad cycles=%0d dat=%h rdy=%b want 0 00000000 1", stray, rsp_dat, cmd_ready);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; dat_i = '0; ack = 1'b0; err = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_zero_wait();
    test_ack_err();
    test_write_wait();
    test_ack_at_timeout();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
